// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind a UART receiver: SYNC, LEN, LEN payload bytes, XOR checksum.
// Payload is buffered and streamed out over valid/ready only after the checksum matches.
module uart_rx_frame_parser #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         MAX_PAYLOAD   = 16,
   parameter int         PAYLOAD_SIZE  = 5,
   parameter int         TIMEOUT_TICKS = 1024,
   parameter int         TIMEOUT_SIZE  = 11
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_rxdata,
   input  logic       i_recvdata,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_last,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t                  state, state_nx;
   logic [PAYLOAD_SIZE-1:0] len, len_nx;
   logic [PAYLOAD_SIZE-1:0] idx, idx_nx;
   logic [PAYLOAD_SIZE-1:0] rd, rd_nx;
   logic [7:0]              csum, csum_nx;
   logic [TIMEOUT_SIZE-1:0] tmo, tmo_nx;
   logic [7:0]              buffer [MAX_PAYLOAD];

   logic       wr_en;
   logic       err_nx;
   logic       ovr_nx;
   logic       valid_nx;
   logic       last_nx;
   logic [7:0] data_nx;
   logic       handshake;
   logic       tmo_hit;

   assign handshake = o_valid & i_ready;
   assign tmo_hit   = (tmo == TIMEOUT_SIZE'(TIMEOUT_TICKS - 1));

   // State and parsing counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_HUNT;
         len   <= '0;
         idx   <= '0;
         rd    <= '0;
         csum  <= 8'h00;
         tmo   <= '0;
      end else begin
         state <= state_nx;
         len   <= len_nx;
         idx   <= idx_nx;
         rd    <= rd_nx;
         csum  <= csum_nx;
         tmo   <= tmo_nx;
      end
   end

   // Payload buffer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < MAX_PAYLOAD; i++) begin
            buffer[i] <= 8'h00;
         end
      end else if (wr_en) begin
         buffer[idx[AW-1:0]] <= i_rxdata;
      end
   end

   // Next-state and counter updates
   always_comb begin
      state_nx = state;
      len_nx   = len;
      idx_nx   = idx;
      rd_nx    = rd;
      csum_nx  = csum;
      tmo_nx   = '0;
      wr_en    = 1'b0;
      err_nx   = 1'b0;
      ovr_nx   = 1'b0;
      case (state)
         ST_HUNT: begin
            if (i_recvdata && (i_rxdata == SYNC_BYTE)) begin
               state_nx = ST_LEN;
            end else begin
               state_nx = ST_HUNT;
            end
         end
         ST_LEN: begin
            if (i_recvdata) begin
               len_nx  = i_rxdata[PAYLOAD_SIZE-1:0];
               csum_nx = i_rxdata;
               if ((i_rxdata == 8'h00) || (i_rxdata > MAX_LEN)) begin
                  err_nx   = 1'b1;
                  state_nx = ST_HUNT;
               end else begin
                  idx_nx   = '0;
                  state_nx = ST_PAYLOAD;
               end
            end else if (tmo_hit) begin
               err_nx   = 1'b1;
               state_nx = ST_HUNT;
            end else begin
               tmo_nx = tmo + TIMEOUT_SIZE'(1);
            end
         end
         ST_PAYLOAD: begin
            if (i_recvdata) begin
               wr_en   = 1'b1;
               csum_nx = csum ^ i_rxdata;
               idx_nx  = idx + PAYLOAD_SIZE'(1);
               if (idx == (len - PAYLOAD_SIZE'(1))) begin
                  state_nx = ST_CHECK;
               end else begin
                  state_nx = ST_PAYLOAD;
               end
            end else if (tmo_hit) begin
               err_nx   = 1'b1;
               state_nx = ST_HUNT;
            end else begin
               tmo_nx = tmo + TIMEOUT_SIZE'(1);
            end
         end
         ST_CHECK: begin
            if (i_recvdata) begin
               if (i_rxdata == csum) begin
                  rd_nx    = '0;
                  state_nx = ST_DRAIN;
               end else begin
                  err_nx   = 1'b1;
                  state_nx = ST_HUNT;
               end
            end else if (tmo_hit) begin
               err_nx   = 1'b1;
               state_nx = ST_HUNT;
            end else begin
               tmo_nx = tmo + TIMEOUT_SIZE'(1);
            end
         end
         ST_DRAIN: begin
            // Bytes arriving while draining are lost, including SYNC_BYTE
            ovr_nx = i_recvdata;
            if (handshake) begin
               rd_nx = rd + PAYLOAD_SIZE'(1);
               if (rd == (len - PAYLOAD_SIZE'(1))) begin
                  state_nx = ST_HUNT;
               end else begin
                  state_nx = ST_DRAIN;
               end
            end else begin
               state_nx = ST_DRAIN;
            end
         end
         default: begin
            state_nx = ST_HUNT;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state
   always_comb begin
      valid_nx = 1'b0;
      data_nx  = 8'h00;
      last_nx  = 1'b0;
      if (state_nx == ST_DRAIN) begin
         valid_nx = 1'b1;
         data_nx  = buffer[rd_nx[AW-1:0]];
         last_nx  = (rd_nx == (len_nx - PAYLOAD_SIZE'(1)));
      end else begin
         valid_nx = 1'b0;
         data_nx  = 8'h00;
         last_nx  = 1'b0;
      end
   end

   // Registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data      <= 8'h00;
         o_valid     <= 1'b0;
         o_last      <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_data      <= data_nx;
         o_valid     <= valid_nx;
         o_last      <= last_nx;
         o_frame_err <= err_nx;
         o_overrun   <= ovr_nx;
         o_busy      <= (state_nx != ST_HUNT);
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed and randomized checks of uart_rx_frame_parser against a stream-level
// reference parser that works on the whole sent byte sequence.
module tb_uart_rx_frame_parser;

   typedef logic [7:0] u8;

   logic       clk;
   logic       i_rst;
   logic [7:0] i_rxdata;
   logic       i_recvdata;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_last;
   logic       i_ready;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int total = 0;
   int bad   = 0;

   u8           stream[$];
   logic [8:0]  got_q[$];
   logic [8:0]  exp_q[$];
   int          mon_err = 0;
   int          mon_ovr = 0;
   int          exp_err = 0;

   uart_rx_frame_parser dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_rxdata   (i_rxdata),
      .i_recvdata (i_recvdata),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .i_ready    (i_ready),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe accepted bytes and pulses mid-cycle
   always @(negedge clk) begin
      if (!i_rst) begin
         if (o_valid && i_ready) got_q.push_back({o_last, o_data});
         if (o_frame_err) mon_err++;
         if (o_overrun) mon_ovr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input u8 b);
      i_rxdata   = b;
      i_recvdata = 1'b1;
      stream.push_back(b);
      tick();
      i_recvdata = 1'b0;
   endtask

   task automatic send_frame(input u8 pl[$], input u8 cs_flip);
      u8 cs;
      cs = u8'(pl.size());
      send_byte(8'hA5);
      send_byte(u8'(pl.size()));
      foreach (pl[k]) begin
         send_byte(pl[k]);
         cs = cs ^ pl[k];
      end
      send_byte(cs ^ cs_flip);
   endtask

   // Called right after the checksum byte with i_ready=1
   task automatic expect_drain(input string tag, input u8 pl[$]);
      foreach (pl[k]) begin
         chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
         chk({tag, "_data"}, {24'd0, o_data}, {24'd0, pl[k]});
         chk({tag, "_last"}, {31'd0, o_last}, (k == pl.size() - 1) ? 32'd1 : 32'd0);
         tick();
      end
      chk({tag, "_end_valid"}, {31'd0, o_valid}, 32'd0);
      chk({tag, "_end_busy"}, {31'd0, o_busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      i_rst = 1'b1;
      #1;
      chk("rst_outputs", {20'd0, o_data, o_valid, o_last, o_frame_err, o_overrun}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   // Reference: parse the whole byte stream by the framing rules
   task automatic run_model();
      int i;
      int len;
      u8  x;
      i = 0;
      exp_q.delete();
      exp_err = 0;
      while (i < stream.size()) begin
         if (stream[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 1 >= stream.size()) break;
         len = int'(stream[i+1]);
         i = i + 2;
         if (len == 0 || len > 16) begin
            exp_err++;
            continue;
         end
         if (i + len >= stream.size()) break;
         x = u8'(len);
         for (int k = 0; k < len; k++) x = x ^ stream[i+k];
         if (x == stream[i+len]) begin
            for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), stream[i+k]});
         end else begin
            exp_err++;
         end
         i = i + len + 1;
      end
   endtask

   initial begin
      u8  pl[$];
      u8  pl2[$];
      int e0;
      int o0;
      int n;
      int len;
      int nchk;

      i_rst      = 1'b1;
      i_rxdata   = 8'h00;
      i_recvdata = 1'b0;
      i_ready    = 1'b1;
      tick();
      tick();
      chk("reset_outputs", {20'd0, o_data, o_valid, o_last, o_frame_err, o_overrun}, 32'd0);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      i_rst = 1'b0;
      tick();

      // Good frame, consecutive bytes
      pl = {8'h11, 8'h22, 8'h33};
      e0 = mon_err;
      send_frame(pl, 8'h00);
      expect_drain("good", pl);
      chk("good_no_err", mon_err - e0, 32'd0);

      // Bad checksum
      send_frame(pl, 8'h07);
      chk("badcs_err", {31'd0, o_frame_err}, 32'd1);
      chk("badcs_valid", {31'd0, o_valid}, 32'd0);
      tick();
      chk("badcs_pulse_end", {30'd0, o_frame_err, o_busy}, 32'd0);

      // LEN out of range
      send_byte(8'hA5);
      send_byte(8'h00);
      chk("len0_err", {30'd0, o_frame_err, o_busy}, 32'd2);
      tick();
      send_byte(8'hA5);
      send_byte(8'h11);
      chk("len17_err", {30'd0, o_frame_err, o_busy}, 32'd2);
      tick();
      chk("len17_pulse_end", {31'd0, o_frame_err}, 32'd0);
      send_frame(pl, 8'h00);
      expect_drain("after_len", pl);

      // Stall with an overrun byte during drain
      o0 = mon_ovr;
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      i_ready = 1'b0;
      send_byte(8'h03);
      chk("stall_first", {23'd0, o_valid, o_data}, {23'd0, 1'b1, 8'h11});
      send_byte(8'h55);
      chk("ovr_pulse", {31'd0, o_overrun}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("stall_hold", {22'd0, o_valid, o_last, o_data}, {22'd0, 1'b1, 1'b0, 8'h11});
      end
      chk("ovr_once", mon_ovr - o0, 32'd1);
      i_ready = 1'b1;
      expect_drain("after_stall", pl);

      // Payload bytes equal to SYNC are data
      pl2 = {8'hA5, 8'hA5};
      send_frame(pl2, 8'h00);
      expect_drain("sync_payload", pl2);

      // Back-to-back: SYNC right after final handshake
      pl2 = {8'h42};
      send_frame(pl2, 8'h00);
      chk("b2b_first", {22'd0, o_valid, o_last, o_data}, {22'd0, 1'b1, 1'b1, 8'h42});
      tick();
      send_frame(pl, 8'h00);
      expect_drain("b2b_second", pl);

      // Garbage then timeout
      e0 = mon_err;
      send_byte(8'h00);
      send_byte(8'hFF);
      tick();
      chk("garbage_quiet", {mon_err - e0, 31'd0, o_busy}, 32'd0);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h7E);
      n = 0;
      while (!o_frame_err && n < 1100) begin
         tick();
         n++;
         if (n == 500) chk("tmo_busy_mid", {31'd0, o_busy}, 32'd1);
      end
      chk("tmo_fired", {31'd0, o_frame_err}, 32'd1);
      chk("tmo_when", (n >= 1023 && n <= 1025) ? 32'd1 : 32'd0, 32'd1);
      chk("tmo_busy", {31'd0, o_busy}, 32'd0);
      tick();
      chk("tmo_pulse_end", {31'd0, o_frame_err}, 32'd0);

      // Reset mid-payload and mid-drain
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      pulse_reset();
      send_frame(pl, 8'h00);
      expect_drain("after_rst_pl", pl);
      i_ready = 1'b0;
      send_frame(pl, 8'h00);
      chk("pre_rst_drain", {31'd0, o_valid}, 32'd1);
      pulse_reset();
      i_ready = 1'b1;
      send_frame(pl, 8'h00);
      expect_drain("after_rst_dr", pl);

      // Randomized frames against the stream model
      stream.delete();
      got_q.delete();
      mon_err = 0;
      mon_ovr = 0;
      for (int f = 0; f < 30; f++) begin
         u8 g;
         u8 cs;
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            g = u8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g);
         end
         len = $urandom_range(0, 18);
         send_byte(8'hA5);
         send_byte(u8'(len));
         if (len >= 1 && len <= 16) begin
            cs = u8'(len);
            for (int k = 0; k < len; k++) begin
               g = u8'($urandom_range(0, 255));
               cs = cs ^ g;
               send_byte(g);
               for (int w = 0; w < $urandom_range(0, 2); w++) tick();
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ u8'($urandom_range(1, 255));
            send_byte(cs);
         end
         for (int w = 0; w < 400 && o_busy; w++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
         i_ready = 1'b1;
         chk("rnd_idle", {31'd0, o_busy}, 32'd0);
      end
      tick();
      run_model();
      chk("rnd_count", got_q.size(), exp_q.size());
      nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int k = 0; k < nchk; k++) begin
         chk("rnd_byte", {23'd0, got_q[k]}, {23'd0, exp_q[k]});
      end
      chk("rnd_frame_err", mon_err, exp_err);
      chk("rnd_overrun", mon_ovr, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
Downstream consumer of the UART receiver's byte strobe. It hunts for a sync byte, then parses a length-prefixed frame: SYNC, LEN, LEN payload bytes, XOR checksum. Payload is held in an internal buffer and released over a valid/ready stream only after the checksum passes. Corrupt, oversize or stalled frames are discarded and flagged.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_PAYLOAD, 16, maximum accepted LEN (1..MAX_PAYLOAD valid)
PAYLOAD_SIZE, 5, bits for LEN/index counters (must hold MAX_PAYLOAD)
TIMEOUT_TICKS, 1024, idle clocks between bytes before a partial frame is aborted
TIMEOUT_SIZE, 11, bits of timeout counter

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_rxdata  input  8  received byte, valid when i_recvdata=1
i_recvdata  input  1  one-cycle byte-received strobe from UART receiver
o_data  output  8  payload byte out
o_valid  output  1  o_data valid
o_last  output  1  o_data is final payload byte of frame
i_ready  input  1  downstream accepts byte when o_valid&i_ready
o_frame_err  output  1  one-cycle pulse: frame discarded (bad LEN, bad checksum, timeout)
o_overrun  output  1  one-cycle pulse: byte arrived while draining, dropped
o_busy  output  1  high in any state other than HUNT

Behaviour:
- Reset (async, i_rst=1): state HUNT; o_valid, o_last, o_frame_err, o_overrun, o_busy = 0; o_data = 0; all counters and running checksum = 0.
- Bytes are consumed only in cycles with i_recvdata=1; no other cycle advances parsing.
- HUNT: byte==SYNC_BYTE -> LEN; any other byte ignored silently (no error).
- LEN: store LEN, checksum := LEN. LEN==0 or LEN>MAX_PAYLOAD -> o_frame_err pulse, -> HUNT. Else index := 0, -> PAYLOAD.
- PAYLOAD: write byte to buffer[index], checksum ^= byte, index++. When index reaches LEN-1 on a write -> CHECK.
- CHECK: byte==checksum -> DRAIN with read index 0; else o_frame_err pulse, -> HUNT.
- DRAIN: o_valid=1, o_data=buffer[rd], o_last=(rd==LEN-1). On o_valid&i_ready: rd++; if o_last, -> HUNT (o_valid low next cycle). o_data/o_last stable while o_valid&!i_ready.
- Output latency: first payload byte valid on the cycle after the checksum strobe.
- Overrun: i_recvdata=1 in DRAIN -> byte dropped, o_overrun pulse next cycle; a SYNC_BYTE in DRAIN is also dropped (not re-synced).
- Timeout: in LEN/PAYLOAD/CHECK, counter clears on each i_recvdata and increments otherwise; reaching TIMEOUT_TICKS-1 -> o_frame_err pulse, -> HUNT. No timeout in HUNT or DRAIN.
- Pulses (o_frame_err, o_overrun) are registered, exactly one cycle wide.
- Checksum is 8-bit XOR over LEN and all payload bytes; SYNC_BYTE excluded.
- Back-to-back frames: a SYNC_BYTE arriving the cycle after final handshake in DRAIN is accepted in HUNT.
- Reset mid-frame or mid-drain: everything discarded, o_valid drops immediately (async).
- Payload bytes equal to SYNC_BYTE are data, not resync points.

Test Plan:
- Good frame A5 03 11 22 33 03, i_ready=1 -> o_data 11,22,33 on consecutive cycles, o_last with 33, no o_frame_err.
- Same frame with checksum 04 -> single o_frame_err pulse after checksum byte, o_valid never asserted, o_busy returns 0.
- A5 00 and A5 11 (LEN=17) -> o_frame_err pulse after LEN byte, return to HUNT; following good frame decoded correctly.
- Good frame then i_ready=0 for 10 cycles while byte 55 arrives -> o_data holds 11, o_overrun pulses once, then 11,22,33 delivered when i_ready=1.
- A5 02 7E then silence for 1024 clocks -> o_frame_err pulse at timeout, o_busy=0; garbage 00 FF before A5 ignored without error.
- Assert i_rst during PAYLOAD and during DRAIN -> all outputs 0 immediately; next good frame decodes normally.
